// File: rtl/if_fetch.sv
`timescale 1ns / 1ps
// Instruction-fetch stage: credit-limited imem requests, in-order response queue, decode handshake.
// Define IF_FETCH_BYPASS_EN to forward a response straight to decode when the queue is empty.
module if_fetch #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] pc_i,
    input  logic             redirect_i,
    input  logic [WIDTH-1:0] redirect_pc_i,
    output logic             pc_load_o,
    output logic [WIDTH-1:0] pc_load_val_o,
    output logic             imem_req_o,
    output logic [WIDTH-1:0] imem_addr_o,
    input  logic             imem_gnt_i,
    input  logic             imem_rvalid_i,
    input  logic [31:0]      imem_rdata_i,
    output logic             if_valid_o,
    input  logic             if_ready_i,
    output logic [WIDTH-1:0] if_pc_o,
    output logic [31:0]      if_instr_o
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW+1:0] DepthC = (CW + 2)'(DEPTH);

    logic [CW-1:0]    out_q, out_d, disc_q, disc_d, occ_q, occ_d;
    logic [PW-1:0]    af_wptr_q, af_wptr_d, af_rptr_q, af_rptr_d;
    logic [PW-1:0]    q_wptr_q, q_wptr_d, q_rptr_q, q_rptr_d;
    logic [WIDTH-1:0] af_addr_q [DEPTH];
    logic [WIDTH-1:0] q_pc_q [DEPTH];
    logic [31:0]      q_instr_q [DEPTH];

    logic             inflight_nz, resp, resp_keep, issue;
    logic             q_empty, q_push, q_pop, byp_valid;
    logic [CW+1:0]    credit_sum;

    assign q_empty     = (occ_q == '0);
    assign inflight_nz = (out_q != '0) || (disc_q != '0);
    // Responses with nothing in flight are ignored (protocol violation).
    assign resp        = imem_rvalid_i && inflight_nz;
    assign resp_keep   = resp && (disc_q == '0) && !redirect_i;
    assign q_pop       = !q_empty && if_ready_i;

`ifdef IF_FETCH_BYPASS_EN
    assign byp_valid = q_empty && resp_keep;
`else
    assign byp_valid = 1'b0;
`endif

    assign q_push = resp_keep && !(byp_valid && if_ready_i);

    // A slot freed by this cycle's pop can be reused: any response to a request issued now
    // arrives no earlier than next cycle, after the pop has taken effect.
    assign credit_sum = {2'b00, out_q} + {2'b00, disc_q} + {2'b00, occ_q}
                      - {{(CW + 1){1'b0}}, q_pop};

    always_comb begin
        imem_req_o    = rst_n_i && !redirect_i && (credit_sum < DepthC);
        imem_addr_o   = pc_i;
        issue         = imem_req_o && imem_gnt_i;
        pc_load_o     = !issue;
        pc_load_val_o = (rst_n_i && redirect_i) ? redirect_pc_i : pc_i;
    end

    always_comb begin
        if_valid_o = !q_empty || byp_valid;
        if_pc_o    = q_pc_q[q_rptr_q];
        if_instr_o = q_instr_q[q_rptr_q];
        if (q_empty && byp_valid) begin
            if_pc_o    = af_addr_q[af_rptr_q];
            if_instr_o = imem_rdata_i;
        end
    end

    always_comb begin
        out_d     = out_q;
        disc_d    = disc_q;
        occ_d     = occ_q;
        af_wptr_d = af_wptr_q + PW'(issue);
        af_rptr_d = af_rptr_q + PW'(resp);
        q_wptr_d  = q_wptr_q;
        q_rptr_d  = q_rptr_q;
        if (redirect_i) begin
            // Everything still in flight becomes a response to drop.
            out_d    = '0;
            disc_d   = out_q + disc_q - CW'(resp);
            occ_d    = '0;
            q_rptr_d = q_wptr_q;
        end else begin
            out_d    = out_q + CW'(issue) - CW'(resp && (disc_q == '0));
            disc_d   = disc_q - CW'(resp && (disc_q != '0));
            occ_d    = occ_q + CW'(q_push) - CW'(q_pop);
            q_wptr_d = q_wptr_q + PW'(q_push);
            q_rptr_d = q_rptr_q + PW'(q_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            out_q     <= '0;
            disc_q    <= '0;
            occ_q     <= '0;
            af_wptr_q <= '0;
            af_rptr_q <= '0;
            q_wptr_q  <= '0;
            q_rptr_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                af_addr_q[i] <= '0;
                q_pc_q[i]    <= '0;
                q_instr_q[i] <= '0;
            end
        end else begin
            out_q     <= out_d;
            disc_q    <= disc_d;
            occ_q     <= occ_d;
            af_wptr_q <= af_wptr_d;
            af_rptr_q <= af_rptr_d;
            q_wptr_q  <= q_wptr_d;
            q_rptr_q  <= q_rptr_d;
            if (issue) begin
                af_addr_q[af_wptr_q] <= pc_i;
            end
            if (q_push) begin
                q_pc_q[q_wptr_q]    <= af_addr_q[af_rptr_q];
                q_instr_q[q_wptr_q] <= imem_rdata_i;
            end
        end
    end

    a_rvalid_expected: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        imem_rvalid_i |-> inflight_nz);

endmodule

// File: tb/tb_if_fetch.sv
`timescale 1ns / 1ps
// Directed bench for if_fetch with a PC-register model and an in-order instruction memory.
module tb_if_fetch;
    localparam logic [31:0] RESET_PC_ADDR = 32'h0000_0000;
`ifdef IF_FETCH_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    logic        clk;
    logic        rst_n;
    logic [31:0] pc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        pc_load;
    logic [31:0] pc_load_val;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    logic        resp_en;
    logic [31:0] pend[$];
    int          checks = 0;
    int          errors = 0;

    if_fetch #(.WIDTH(32), .DEPTH(2)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .pc_i         (pc),
        .redirect_i   (redirect),
        .redirect_pc_i(redirect_pc),
        .pc_load_o    (pc_load),
        .pc_load_val_o(pc_load_val),
        .imem_req_o   (imem_req),
        .imem_addr_o  (imem_addr),
        .imem_gnt_i   (imem_gnt),
        .imem_rvalid_i(imem_rvalid),
        .imem_rdata_i (imem_rdata),
        .if_valid_o   (if_valid),
        .if_ready_i   (if_ready),
        .if_pc_o      (if_pc),
        .if_instr_o   (if_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PC register: holds/jumps when pc_load is high, otherwise advances by 4.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc <= RESET_PC_ADDR;
        else        pc <= pc_load ? pc_load_val : pc + 32'd4;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0050_0093 + (a << 10);
    endfunction

    // Memory: answers in order, earliest one cycle after the grant, while resp_en is set.
    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                pend.delete();
            end else begin
                if (imem_rvalid && pend.size() > 0) void'(pend.pop_front());
                if (imem_req && imem_gnt) pend.push_back(imem_addr);
            end
            #1;
            if (rst_n && resp_en && pend.size() > 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(pend[0]);
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = 32'h0;
            end
        end
    end

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Leaves the bench 2 ns into the first cycle after reset release.
    task automatic do_reset();
        tick();
        rst_n    = 1'b0;
        redirect = 1'b0;
        resp_en  = 1'b1;
        if_ready = 1'b1;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk1({tag, " valid"}, if_valid, 1'b0);
        chk1({tag, " req"}, imem_req, 1'b0);
        chk32({tag, " if_pc"}, if_pc, 32'h0);
        chk32({tag, " if_instr"}, if_instr, 32'h0);
        chk1({tag, " pc_load"}, pc_load, 1'b1);
        chk32({tag, " pc_load_val"}, pc_load_val, RESET_PC_ADDR);
    endtask

    // Waits up to 12 cycles for if_valid, then checks the presented entry.
    task automatic expect_first(input string tag, input logic [31:0] epc);
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < 12 && !seen; c++) begin
            tick();
            #1;
            if (if_valid) seen = 1'b1;
        end
        chk1({tag, " valid seen"}, seen, 1'b1);
        if (seen) begin
            chk32({tag, " pc"}, if_pc, epc);
            chk32({tag, " instr"}, if_instr, mem_word(epc));
        end
    endtask

    initial begin
        int first;
        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_gnt    = 1'b1;
        if_ready    = 1'b1;
        resp_en     = 1'b1;

        // Reset values, then streaming from RESET_PC_ADDR.
        tick();
        tick();
        #1;
        check_reset_outputs("reset");
        tick();
        rst_n = 1'b1;
        #1;
        chk1("rel req", imem_req, 1'b1);
        chk32("rel addr", imem_addr, RESET_PC_ADDR);
        chk1("rel pc_load", pc_load, 1'b0);
        first = (BYP != 0) ? 1 : 2;
        for (int c = 1; c <= first + 3; c++) begin
            tick();
            #1;
            chk1("stream pc_load", pc_load, 1'b0);
            if (c < first) begin
                chk1("stream early valid", if_valid, 1'b0);
            end else begin
                chk1("stream valid", if_valid, 1'b1);
                chk32("stream pc", if_pc, 32'((c - first) * 4));
                chk32("stream instr", if_instr, mem_word(32'((c - first) * 4)));
            end
        end

        // Backpressure: queue fills with 0x0, 0x4 and the PC holds at 0x8.
        do_reset();
        if_ready = 1'b0;
        #1;
        chk1("bp c0 req", imem_req, 1'b1);
        for (int c = 1; c <= 5; c++) begin
            tick();
            #1;
            if (c >= 2) begin
                chk1("bp req", imem_req, 1'b0);
                chk1("bp pc_load", pc_load, 1'b1);
                chk32("bp pc_load_val", pc_load_val, 32'h8);
                chk1("bp valid", if_valid, 1'b1);
                chk32("bp if_pc", if_pc, 32'h0);
            end
        end
        tick();
        if_ready = 1'b1;
        #1;
        chk1("bp drain0 valid", if_valid, 1'b1);
        chk32("bp drain0 pc", if_pc, 32'h0);
        chk32("bp drain0 instr", if_instr, 32'h0050_0093);
        tick();
        #1;
        chk1("bp drain1 valid", if_valid, 1'b1);
        chk32("bp drain1 pc", if_pc, 32'h4);
        chk32("bp drain1 instr", if_instr, 32'h0050_1093);
        tick();
        #1;
        chk1("bp drain2 valid", if_valid, 1'b1);
        chk32("bp drain2 pc", if_pc, 32'h8);
        chk32("bp drain2 instr", if_instr, 32'h0050_2093);

        // Redirect with two requests in flight: both old responses are dropped.
        do_reset();
        resp_en = 1'b0;
        tick();
        tick();
        #1;
        chk1("rd full req", imem_req, 1'b0);
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        resp_en     = 1'b1;
        #1;
        chk1("rd pc_load", pc_load, 1'b1);
        chk32("rd pc_load_val", pc_load_val, 32'h100);
        chk1("rd req", imem_req, 1'b0);
        tick();
        redirect = 1'b0;
        #1;
        chk1("rd after valid", if_valid, 1'b0);
        chk1("rd after req", imem_req, 1'b0);
        expect_first("rd first", 32'h100);

        // Redirect in the same cycle as a grant: nothing is recorded.
        do_reset();
        resp_en     = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        #1;
        chk1("rg req", imem_req, 1'b0);
        chk1("rg pc_load", pc_load, 1'b1);
        chk32("rg pc_load_val", pc_load_val, 32'h40);
        tick();
        redirect = 1'b0;
        resp_en  = 1'b1;
        #1;
        chk1("rg next req", imem_req, 1'b1);
        chk32("rg next addr", imem_addr, 32'h40);
        expect_first("rg first", 32'h40);

        // Redirect in the same cycle as a response: that word is dropped, one left to discard.
        do_reset();
        resp_en = 1'b0;
        tick();
        tick();
        resp_en = 1'b1;
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        #1;
        chk1("rr rvalid present", imem_rvalid, 1'b1);
        chk1("rr valid", if_valid, 1'b0);
        chk1("rr req", imem_req, 1'b0);
        chk32("rr pc_load_val", pc_load_val, 32'h200);
        tick();
        redirect = 1'b0;
        #1;
        chk1("rr next valid", if_valid, 1'b0);
        chk1("rr next req", imem_req, 1'b1);
        chk32("rr next addr", imem_addr, 32'h200);
        expect_first("rr first", 32'h200);

        // Reset mid-run with two outstanding; memory is reset too.
        do_reset();
        resp_en = 1'b0;
        tick();
        tick();
        resp_en = 1'b1;
        rst_n   = 1'b0;
        #1;
        check_reset_outputs("mid reset");
        tick();
        rst_n = 1'b1;
        #1;
        chk1("mid rel req", imem_req, 1'b1);
        chk32("mid rel addr", imem_addr, RESET_PC_ADDR);
        expect_first("mid first", RESET_PC_ADDR);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
